window_builder: RTL and testbench
=================================

// Module: window_builder
// PURPOSE
//   Streams raster-order RGB pixels and produces one 3x3 neighbourhood per interior pixel.
//   Output is a 216-bit packed window, the pixeldata word consumed by the intensity stage.
//   Sits between the frame source (SRAM reader / camera path) and the intensity/edge pipeline.
//   Two line buffers plus a 3x3 shift register; valid/ready on both sides.
// PARAMETERS
//   IMG_WIDTH   640  pixels per line (>=3)
//   IMG_HEIGHT  480  lines per frame (>=3)
//   XW          $clog2(IMG_WIDTH)   column counter / win_x width (derived, localparam)
//   YW          $clog2(IMG_HEIGHT)  row counter / win_y width (derived, localparam)
// PORTS
//   clk         in   1    system clock; all logic on posedge
//   n_rst       in   1    synchronous reset, ACTIVE-HIGH (1 = reset), sampled on posedge clk
//   pix_valid   in   1    pix_data/pix_sof valid
//   pix_ready   out  1    builder can accept a pixel this cycle
//   pix_sof     in   1    qualifies pixel as frame position (0,0)
//   pix_data    in   24   RGB pixel {R[23:16],G[15:8],B[7:0]}
//   win_valid   out  1    pixeldata/win_x/win_y hold a window
//   win_ready   in   1    downstream accepts window
//   pixeldata   out  216  3x3 window, row-major; [215:192]=(x-1,y-1) ... [23:0]=(x+1,y+1)
//   win_x       out  XW   window centre column
//   win_y       out  YW   window centre row
//   frame_done  out  1    one-cycle pulse, cycle after last pixel of a frame accepted
// BEHAVIOUR
//   - Pixel accepted when pix_valid && pix_ready; pix_ready = !win_valid || win_ready (comb).
//   - Counters col,row give position of the accepted pixel; accepted with pix_sof=1 -> treated as (0,0).
//   - Per accepted pixel at (col,row): shift window one column left; new right column =
//     {lb1[col], lb0[col], pix_data} (top..bottom); lb1[col]<=lb0[col]; lb0[col]<=pix_data.
//   - col increments; at IMG_WIDTH-1 wraps to 0 and row increments; at (W-1,H-1) both wrap to 0.
//   - Window emitted when accepted pixel has col>=2 && row>=2: next cycle win_valid=1,
//     pixeldata = updated window, win_x=col-1, win_y=row-1. Latency 1 cycle; (W-2)*(H-2) windows/frame.
//   - No window for col<2 or row<2 (border, stale line-buffer/shift data never emitted).
//   - Output held stable while win_valid && !win_ready. Clear on win_ready unless a new window
//     loads same cycle (back-to-back: one window per cycle at full throughput).
//   - frame_done=1 cycle after accept of (W-1,H-1); independent of win handshake.
//   - pix_sof on a pixel not at (0,0): counters resync to (0,0), no error; lb contents reused
//     but windows suppressed until row>=2 again.
//   - Reset (any time, incl. mid-frame/mid-stall): col=0,row=0,win_valid=0,pixeldata=0,win_x=0,
//     win_y=0,frame_done=0; pending window discarded. Line buffers/shift reg not reset.
//   - Line buffers: single-write/single-read per cycle, read-before-write same address.
// TESTING (IMG_WIDTH=4, IMG_HEIGHT=4, pix_data = row*4+col, win_ready=1)
//   1 Stream 16 pixels, sof on first -> first window cycle after pixel 10:
//     win_x=1,win_y=1, pixeldata={0,1,2,4,5,6,8,9,10}.
//   2 Same frame -> exactly 4 windows, centres (1,1),(2,1),(1,2),(2,2); 4th={5,6,7,9,10,11,13,14,15};
//     frame_done pulses once after pixel 15.
//   3 Hold win_ready=0 after first window for 5 cycles -> pix_ready=0, outputs stable;
//     release -> next window follows, no pixel lost or duplicated.
//   4 Two frames back-to-back, pix_valid always 1 -> 8 windows, second frame identical
//     to first, no windows straddle frames.
//   5 Assert pix_sof on pixel 6 of frame -> counters restart; next window only after
//     2 full rows + 3 pixels, centre (1,1).
//   6 Assert n_rst=1 for 1 cycle while win_valid=1 and stalled -> win_valid=0, pixeldata=0
//     next cycle; fresh frame then reproduces test 1.

Source files
------------

// File: rtl/window_builder.sv
// rtl/window_builder.sv - raster RGB stream to 3x3 neighbourhood window builder
//
// Purpose: accepts raster-order 24-bit RGB pixels and, for every interior
// pixel, emits the 3x3 neighbourhood centred on it as one 216-bit word.
// Two line buffers hold the previous two lines; a 3x3 shift register holds
// the current window, which slides one column per accepted pixel.
//
// Ports:
//   clk        system clock, all logic on posedge
//   n_rst      synchronous reset, active-high
//   pix_valid  input pixel valid
//   pix_ready  builder can accept a pixel this cycle (combinational)
//   pix_sof    marks the accepted pixel as frame position (0,0)
//   pix_data   RGB pixel {R,G,B}
//   win_valid  window outputs hold a window
//   win_ready  downstream accepts the window
//   pixeldata  3x3 window, row-major, [215:192] = top-left, [23:0] = bottom-right
//   win_x      window centre column
//   win_y      window centre row
//   frame_done one-cycle pulse after the last pixel of a frame is accepted

module window_builder #(
    parameter  int IMG_WIDTH  = 640,
    parameter  int IMG_HEIGHT = 480,
    localparam int XW         = $clog2(IMG_WIDTH),
    localparam int YW         = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          pix_sof,
    input  logic [23:0]   pix_data,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [215:0]  pixeldata,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic          frame_done
);

    // Pixel position counters
    logic [XW-1:0] col_q, col_d, eff_col;
    logic [YW-1:0] row_q, row_d, eff_row;

    // Line buffers: lb0 = previous line, lb1 = line before that
    logic [23:0] lb0_q [IMG_WIDTH];
    logic [23:0] lb1_q [IMG_WIDTH];
    logic [23:0] lb0_rd, lb1_rd;

    // Window shift register, row-major: 0..2 top row, 6..8 bottom row
    logic [23:0] win_q [9];
    logic [23:0] win_d [9];
    logic [215:0] win_flat;

    // Registered outputs
    logic          win_valid_q;
    logic [215:0]  pixeldata_q;
    logic [XW-1:0] win_x_q;
    logic [YW-1:0] win_y_q;
    logic          frame_done_q;

    logic accept, emit, last_col, last_row;

    assign pix_ready  = !win_valid_q || win_ready;
    assign win_valid  = win_valid_q;
    assign pixeldata  = pixeldata_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;

    always_comb begin
        accept  = pix_valid && pix_ready;
        // A start-of-frame pixel is taken as (0,0) whatever the counters say
        eff_col = pix_sof ? '0 : col_q;
        eff_row = pix_sof ? '0 : row_q;

        lb0_rd  = lb0_q[eff_col];
        lb1_rd  = lb1_q[eff_col];

        // Slide left; new right column is {two lines up, one line up, current}
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = lb1_rd;
        win_d[3] = win_q[4];
        win_d[4] = win_q[5];
        win_d[5] = lb0_rd;
        win_d[6] = win_q[7];
        win_d[7] = win_q[8];
        win_d[8] = pix_data;

        win_flat = {win_d[0], win_d[1], win_d[2],
                    win_d[3], win_d[4], win_d[5],
                    win_d[6], win_d[7], win_d[8]};

        last_col = (eff_col == XW'(IMG_WIDTH - 1));
        last_row = (eff_row == YW'(IMG_HEIGHT - 1));

        col_d = last_col ? '0 : eff_col + XW'(1);
        row_d = eff_row;
        if (last_col) begin
            row_d = last_row ? '0 : eff_row + YW'(1);
        end

        // Only interior centres: the window needs two full lines and two
        // pixels of the current line, otherwise it would contain stale data
        emit = accept && (eff_col >= XW'(2)) && (eff_row >= YW'(2));
    end

    // Storage: deliberately not reset; never observable before being refilled
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[eff_col] <= lb0_rd;
            lb0_q[eff_col] <= pix_data;
            win_q          <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            pixeldata_q  <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            frame_done_q <= accept && last_col && last_row;
            // A new window can only load when the old one is gone or leaving,
            // since accept already requires pix_ready
            if (emit) begin
                win_valid_q <= 1'b1;
                pixeldata_q <= win_flat;
                win_x_q     <= eff_col - XW'(1);
                win_y_q     <= eff_row - YW'(1);
            end else if (win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_builder.sv
// tb/tb_window_builder.sv - self-checking bench for window_builder

module tb_window_builder;

    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         pix_valid;
    logic         pix_ready;
    logic         pix_sof;
    logic [23:0]  pix_data;
    logic         win_valid;
    logic         win_ready;
    logic [215:0] pixeldata;
    logic [1:0]   win_x;
    logic [1:0]   win_y;
    logic         frame_done;

    always #5 clk = ~clk;

    window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .n_rst(n_rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_data(pix_data),
        .win_valid(win_valid), .win_ready(win_ready),
        .pixeldata(pixeldata), .win_x(win_x), .win_y(win_y),
        .frame_done(frame_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [215:0] lit(input int p0, input int p1, input int p2,
                                         input int p3, input int p4, input int p5,
                                         input int p6, input int p7, input int p8);
        return {24'(p0), 24'(p1), 24'(p2), 24'(p3), 24'(p4),
                24'(p5), 24'(p6), 24'(p7), 24'(p8)};
    endfunction

    // Reference model: frame image indexed by position, window read straight from it
    logic [23:0]  img [H][W];
    int           m_col = 0, m_row = 0, mc, mr;
    bit           m_valid = 0, m_fd = 0, m_acc = 0, m_nv;
    logic [215:0] m_data = '0;
    int           m_x = 0, m_y = 0;
    bit           chk_en = 0;

    function automatic logic [215:0] window_at(input int c, input int r);
        logic [215:0] d = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                d = {d[191:0], img[r-2+dy][c-2+dx]};
        return d;
    endfunction

    always @(posedge clk) begin
        if (n_rst) begin
            m_col = 0; m_row = 0; m_valid = 0; m_data = '0;
            m_x = 0; m_y = 0; m_fd = 0; m_acc = 0;
        end else begin
            m_acc = pix_valid && (!m_valid || win_ready);
            m_nv  = m_valid && !win_ready;
            m_fd  = 0;
            if (m_acc) begin
                mc = pix_sof ? 0 : m_col;
                mr = pix_sof ? 0 : m_row;
                img[mr][mc] = pix_data;
                if (mc >= 2 && mr >= 2) begin
                    m_nv = 1; m_data = window_at(mc, mr); m_x = mc - 1; m_y = mr - 1;
                end
                m_fd  = (mc == W-1) && (mr == H-1);
                m_col = (mc + 1) % W;
                m_row = (mc == W-1) ? (mr + 1) % H : mr;
            end
            m_valid = m_nv;
        end
    end

    // Observed windows (handshaken) and frame_done pulses
    int           obs_x[$];
    int           obs_y[$];
    logic [215:0] obs_d[$];
    int           fd_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("win_valid", 216'(win_valid), 216'(m_valid));
            chk("pix_ready", 216'(pix_ready), 216'(!m_valid || win_ready));
            chk("frame_done", 216'(frame_done), 216'(m_fd));
            if (m_valid) begin
                chk("pixeldata", pixeldata, m_data);
                chk("win_x", 216'(win_x), 216'(m_x));
                chk("win_y", 216'(win_y), 216'(m_y));
            end
            if (win_valid && win_ready) begin
                obs_x.push_back(int'(win_x));
                obs_y.push_back(int'(win_y));
                obs_d.push_back(pixeldata);
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic clear_obs();
        obs_x.delete(); obs_y.delete(); obs_d.delete(); fd_cnt = 0;
    endtask

    task automatic send(input int d, input bit sof);
        int t = 0;
        pix_valid = 1'b1; pix_data = 24'(d); pix_sof = sof;
        do begin
            @(posedge clk); #1; t++;
        end while (!m_acc && t < 50);
        if (!m_acc) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%0d", d);
        end
        pix_sof = 1'b0;
    endtask

    // Sends pixels lo..hi of a frame whose values equal their raster index
    task automatic frame_part(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            send(k, k == 0);
            if (k == 9) chk("no_window_before_px10", 216'(win_valid), 216'(0));
            if (k == 10) begin
                chk("first_win_valid", 216'(win_valid), 216'(1));
                chk("first_win_x", 216'(win_x), 216'(1));
                chk("first_win_y", 216'(win_y), 216'(1));
                chk("first_win_data", pixeldata, lit(0, 1, 2, 4, 5, 6, 8, 9, 10));
            end
        end
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_one_frame(input string tag);
        chk({tag, "_count"}, 216'(obs_d.size()), 216'(4));
        if (obs_d.size() >= 4) begin
            chk({tag, "_w0"}, obs_d[0], lit(0, 1, 2, 4, 5, 6, 8, 9, 10));
            chk({tag, "_w1"}, obs_d[1], lit(1, 2, 3, 5, 6, 7, 9, 10, 11));
            chk({tag, "_w3"}, obs_d[3], lit(5, 6, 7, 9, 10, 11, 13, 14, 15));
            chk({tag, "_c1"}, 216'({obs_x[1], obs_y[1]}), 216'({32'd2, 32'd1}));
            chk({tag, "_c2"}, 216'({obs_x[2], obs_y[2]}), 216'({32'd1, 32'd2}));
            chk({tag, "_c3"}, 216'({obs_x[3], obs_y[3]}), 216'({32'd2, 32'd2}));
        end
    endtask

    logic [215:0] hold;

    initial begin
        n_rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1; n_rst = 1'b0; chk_en = 1;
        @(negedge clk);
        chk("rst_win_valid", 216'(win_valid), 216'(0));
        chk("rst_pixeldata", pixeldata, 216'(0));
        chk("rst_win_xy", 216'({win_x, win_y}), 216'(0));
        chk("rst_frame_done", 216'(frame_done), 216'(0));
        @(posedge clk); #1;

        // Single frame, free-flowing output
        clear_obs();
        frame_part(0, 15);
        idle();
        check_one_frame("t2");
        chk("t2_frame_done", 216'(fd_cnt), 216'(1));

        // Downstream stall after the first window
        clear_obs();
        frame_part(0, 10);
        win_ready = 1'b0; pix_data = 24'd11;
        hold = pixeldata;
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_ready", 216'(pix_ready), 216'(0));
            chk("t3_stall_data", pixeldata, hold);
        end
        win_ready = 1'b1;
        frame_part(11, 15);
        idle();
        check_one_frame("t3");

        // Two frames back to back
        clear_obs();
        frame_part(0, 15);
        frame_part(0, 15);
        idle();
        chk("t4_count", 216'(obs_d.size()), 216'(8));
        if (obs_d.size() >= 8)
            for (int i = 0; i < 4; i++) begin
                chk("t4_repeat_data", obs_d[i+4], obs_d[i]);
                chk("t4_repeat_xy", 216'({obs_x[i+4], obs_y[i+4]}), 216'({obs_x[i], obs_y[i]}));
            end
        chk("t4_frame_done", 216'(fd_cnt), 216'(2));

        // Resync: sof arrives on pixel 6 of a frame
        clear_obs();
        for (int k = 0; k < 6; k++) send(100 + k, k == 0);
        chk("t5_none_before_resync", 216'(obs_d.size()), 216'(0));
        frame_part(0, 15);
        idle();
        check_one_frame("t5");

        // Reset while stalled with a pending window
        frame_part(0, 10);
        win_ready = 1'b0; pix_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_pending", 216'(win_valid), 216'(1));
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0; win_ready = 1'b1;
        chk("t6_rst_valid", 216'(win_valid), 216'(0));
        chk("t6_rst_data", pixeldata, 216'(0));
        chk("t6_rst_xy", 216'({win_x, win_y}), 216'(0));
        clear_obs();
        frame_part(0, 15);
        idle();
        check_one_frame("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
